// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and the size-code decoder for the matrix unary unit.
package matrix_pkg;

  localparam int ELEM_W_DEF  = 8;
  localparam int MAX_DIM_DEF = 5;

  localparam logic [1:0] OP_NEG  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size code c selects an N x N matrix with N = c + 2, clamped to the largest supported size.
  function automatic logic [3:0] size_to_dim(input logic [2:0] code, input int max_dim);
    logic [3:0] n;
    n = {1'b0, code} + 4'd2;
    if (int'(n) > max_dim) n = 4'(max_dim);
    return n;
  endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// One element lane: applies the unary op at full precision and saturates to ELEM_W signed.
module matrix_elem_alu
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic signed [ELEM_W-1:0] elem,
  input  logic        [1:0]        op,
  input  logic signed [ELEM_W-1:0] scalar,
  output logic signed [ELEM_W-1:0] res,
  output logic                     sat
);

  localparam int FW = 2 * ELEM_W + 1;

  logic signed [FW-1:0]     x;
  logic signed [FW-1:0]     full;
  logic        [FW-ELEM_W:0] top;

  always_comb begin
    x    = FW'(elem);
    full = '0;
    case (op)
      OP_NEG:  full = -x;
      OP_MUL:  full = x * FW'(scalar);
      OP_ABS:  full = x[FW-1] ? -x : x;
      default: full = x;
    endcase
    // The value fits in ELEM_W bits only when every bit above the sign bit repeats it.
    top = full[FW-1:ELEM_W-1];
    sat = !((top == '0) || (top == '1));
    if (sat) res = full[FW-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
    else     res = full[ELEM_W-1:0];
  end

endmodule

// File: rtl/matrix_unary_unit.sv
// Applies one unary op to an N x N matrix, LANES elements per RUN cycle, with saturation tracking.
// Handshake: start is accepted only in IDLE or DONE; busy is high for the RUN cycles; done pulses once on the first DONE cycle and result_valid then holds until the next accepted start.
module matrix_unary_unit
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int LANES   = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [1:0]                            op,
  input  logic [2:0]                            matrix_size,
  input  logic signed [ELEM_W-1:0]              scalar,
  input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]     matrix_a,
  output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]     result,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  result_valid,
  output logic                                  overflow,
  output state_t                                state_dbg
);

  localparam int NE    = MAX_DIM * MAX_DIM;
  localparam int VW    = ELEM_W * NE;
  localparam int IDX_W = $clog2(2 * NE + LANES + 1);

  state_t                   state, state_nxt;
  logic [VW-1:0]            a_q;
  logic [1:0]               op_q;
  logic signed [ELEM_W-1:0] scalar_q;
  logic [3:0]               n_q;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         nn;
  logic                     accept;
  logic                     last;

  logic [IDX_W-1:0]         lane_idx [LANES];
  logic                     lane_en  [LANES];
  logic signed [ELEM_W-1:0] lane_in  [LANES];
  logic signed [ELEM_W-1:0] lane_out [LANES];
  logic                     lane_sat [LANES];

  assign nn        = IDX_W'(n_q) * IDX_W'(n_q);
  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign last      = (idx + IDX_W'(LANES)) >= nn;
  assign busy      = (state == ST_RUN);
  assign state_dbg = state;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = idx + IDX_W'(l);
    assign lane_en[l]  = lane_idx[l] < nn;
    assign lane_in[l]  = lane_en[l] ? a_q[lane_idx[l]*ELEM_W +: ELEM_W] : '0;

    matrix_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
      .elem   (lane_in[l]),
      .op     (op_q),
      .scalar (scalar_q),
      .res    (lane_out[l]),
      .sat    (lane_sat[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q          <= '0;
      op_q         <= OP_NEG;
      scalar_q     <= '0;
      n_q          <= 4'd2;
      idx          <= '0;
      result       <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q          <= matrix_a;
        op_q         <= op;
        scalar_q     <= scalar;
        n_q          <= size_to_dim(matrix_size, MAX_DIM);
        idx          <= '0;
        result       <= '0;
        overflow     <= 1'b0;
        result_valid <= 1'b0;
      end else if (state == ST_RUN) begin
        // Lanes past N*N stay idle so unused result elements keep their cleared zero.
        for (int l = 0; l < LANES; l++) begin
          if (lane_en[l]) begin
            result[lane_idx[l]*ELEM_W +: ELEM_W] <= lane_out[l];
            if (lane_sat[l]) overflow <= 1'b1;
          end
        end
        idx <= idx + IDX_W'(LANES);
        if (last) begin
          done         <= 1'b1;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_unary_unit.sv
// Drives two matrix_unary_unit instances (LANES=5 and LANES=3) with shared stimulus against an arithmetic model.
module tb_matrix_unary_unit;
  import matrix_pkg::*;

  localparam int EW = 8;
  localparam int MD = 5;
  localparam int NE = MD * MD;
  localparam int RW = EW * NE;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [1:0]           op;
  logic [2:0]           matrix_size;
  logic signed [EW-1:0] scalar;
  logic [RW-1:0]        matrix_a;

  logic [RW-1:0] res5, res3;
  logic          busy5, busy3, done5, done3, rv5, rv3, ov5, ov3;
  state_t        st5, st3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  matrix_unary_unit #(.ELEM_W(EW), .MAX_DIM(MD), .LANES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .matrix_size(matrix_size),
    .scalar(scalar), .matrix_a(matrix_a), .result(res5), .busy(busy5), .done(done5),
    .result_valid(rv5), .overflow(ov5), .state_dbg(st5)
  );

  matrix_unary_unit #(.ELEM_W(EW), .MAX_DIM(MD), .LANES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .matrix_size(matrix_size),
    .scalar(scalar), .matrix_a(matrix_a), .result(res3), .busy(busy3), .done(done3),
    .result_valid(rv3), .overflow(ov3), .state_dbg(st3)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, clip to the signed element range.
  task automatic model(input logic [1:0] o, input logic [2:0] code, input logic signed [EW-1:0] s,
                       input logic [RW-1:0] a, output logic [RW-1:0] r, output logic ov, output int nn);
    int n, x, y, si;
    int maxv, minv;
    maxv = (1 <<< (EW - 1)) - 1;
    minv = -(1 <<< (EW - 1));
    n = int'(code) + 2;
    if (n > MD) n = MD;
    nn = n * n;
    si = s;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < nn; i++) begin
      x = $signed(a[i*EW +: EW]);
      case (o)
        2'b00:   y = -x;
        2'b01:   y = x * si;
        2'b10:   y = (x < 0) ? -x : x;
        default: y = x;
      endcase
      if (y > maxv) begin y = maxv; ov = 1'b1; end
      else if (y < minv) begin y = minv; ov = 1'b1; end
      r[i*EW +: EW] = y[EW-1:0];
    end
  endtask

  function automatic logic [RW-1:0] rand_matrix();
    logic [RW-1:0] m;
    for (int i = 0; i < NE; i++) begin
      if ($urandom_range(0, 7) == 0) m[i*EW +: EW] = 8'h80;
      else                           m[i*EW +: EW] = EW'($urandom_range(0, 255));
    end
    return m;
  endfunction

  // Driver: one operation on both instances, checking cycle timing, result and overflow.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] code,
                        input logic signed [EW-1:0] s, input logic [RW-1:0] a, input bit mid_pulse);
    logic [RW-1:0] exp_r;
    logic [RW-1:0] exp_now;
    logic          exp_ov;
    int nn, r5, r3, rmax;
    int busy_err5, busy_err3, done_cyc5, done_cyc3, done_cnt5, done_cnt3;
    model(o, code, s, a, exp_r, exp_ov, nn);
    exp_q.push_back(exp_r);
    r5 = (nn + 4) / 5;
    r3 = (nn + 2) / 3;
    rmax = (r5 > r3) ? r5 : r3;
    busy_err5 = 0; busy_err3 = 0; done_cyc5 = 0; done_cyc3 = 0; done_cnt5 = 0; done_cnt3 = 0;

    @(negedge clk);
    op = o; matrix_size = code; scalar = s; matrix_a = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " cleared_on_start"}, {rv5, rv3, ov5, ov3, done5, done3}, '0);
    for (int c = 1; c <= rmax + 2; c++) begin
      if (c > 1) @(negedge clk);
      if (busy5 !== (c <= r5)) busy_err5++;
      if (busy3 !== (c <= r3)) busy_err3++;
      if (done5 === 1'b1) begin done_cnt5++; if (done_cyc5 == 0) done_cyc5 = c; end
      if (done3 === 1'b1) begin done_cnt3++; if (done_cyc3 == 0) done_cyc3 = c; end
      if (mid_pulse && c == 2) begin
        start = 1'b1; op = ~o; matrix_size = ~code; scalar = ~s; matrix_a = ~a;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, " busy_profile_l5"}, busy_err5, 0);
    check({tag, " busy_profile_l3"}, busy_err3, 0);
    check({tag, " done_cycle_l5"}, done_cyc5, r5 + 1);
    check({tag, " done_cycle_l3"}, done_cyc3, r3 + 1);
    check({tag, " done_pulses"}, {done_cnt5[7:0], done_cnt3[7:0]}, 16'h0101);
    check({tag, " valid_state"}, {rv5, rv3, st5, st3}, {2'b11, ST_DONE, ST_DONE});
    check({tag, " overflow"}, {ov5, ov3}, {exp_ov, exp_ov});
    exp_now = exp_q.pop_front();
    check({tag, " result_l5"}, res5, exp_now);
    check({tag, " result_l3"}, res3, exp_now);
    // Inputs wandering while in DONE must not disturb the held result.
    matrix_a = rand_matrix(); op = 2'($urandom_range(0, 3)); scalar = EW'($urandom_range(0, 255));
    @(negedge clk);
    @(negedge clk);
    check({tag, " hold_in_done"}, res5, exp_now);
  endtask

  initial begin : stim
    logic [RW-1:0] a;
    int dcnt, bcnt;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; matrix_size = 3'd0; scalar = '0; matrix_a = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {res5, busy5, done5, rv5, ov5, res3, busy3, done3, rv3, ov3}, '0);
    check("reset_state", {st5, st3}, {ST_IDLE, ST_IDLE});
    rst_n = 1'b1;

    // N=2 negate, stray data outside the 2x2 window must not leak into the result
    a = rand_matrix();
    a[31:0] = {8'h7F, 8'h00, 8'hFD, 8'h05};
    run_op("n2_neg", OP_NEG, 3'd0, 8'sd0, a, 1'b0);
    check("n2_neg low_elems", res5[31:0], 32'h8100_03FB);
    check("n2_neg upper_zero", res5[RW-1:32], '0);

    // N=5 negate with -128 at element 7
    a = rand_matrix();
    a[7*EW +: EW] = 8'h80;
    run_op("n5_neg", OP_NEG, 3'd3, 8'sd0, a, 1'b0);
    check("n5_neg elem7", res5[7*EW +: EW], 8'h7F);
    check("n5_neg ovf", ov5, 1'b1);

    // N=3 scalar multiply, saturating and non-saturating
    a = '0;
    for (int i = 0; i < 9; i++) a[i*EW +: EW] = 8'd40;
    run_op("n3_mul4", OP_MUL, 3'd1, 8'sd4, a, 1'b0);
    check("n3_mul4 elems", res5[71:0], {9{8'h7F}});
    a = '0;
    for (int i = 0; i < 9; i++) a[i*EW +: EW] = 8'd10;
    run_op("n3_mulm2", OP_MUL, 3'd1, -8'sd2, a, 1'b0);
    check("n3_mulm2 elems", res5[71:0], {9{8'hEC}});
    check("n3_mulm2 ovf", ov5, 1'b0);

    // N=4 abs with a start pulse and operand changes mid-RUN
    run_op("n4_abs_midstart", OP_ABS, 3'd2, 8'sd0, rand_matrix(), 1'b1);

    // Back-to-back restarts from DONE, size clamp, and random ops
    run_op("clamp_pass", OP_PASS, 3'd7, 8'sd0, rand_matrix(), 1'b0);
    for (int k = 0; k < 8; k++) begin
      run_op($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             EW'($urandom_range(0, 255)), rand_matrix(), 1'b0);
    end

    // Reset on RUN cycle 2 aborts without a done pulse; start alongside reset is ignored
    a = rand_matrix();
    a[7:0] = 8'h80;
    @(negedge clk);
    op = OP_NEG; matrix_size = 3'd3; scalar = '0; matrix_a = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy_before_reset", {busy5, busy3}, 2'b11);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("abort outputs_zero", {res5, busy5, done5, rv5, ov5, res3, busy3, done3, rv3, ov3}, '0);
    check("abort state_idle", {st5, st3}, {ST_IDLE, ST_IDLE});
    rst_n = 1'b1; start = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done5 !== 1'b0 || done3 !== 1'b0) dcnt++;
      if (busy5 !== 1'b0 || busy3 !== 1'b0) bcnt++;
    end
    check("abort no_done", dcnt, 0);
    check("abort stays_idle", bcnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_unary_unit.md
MATRIX_UNARY_UNIT -- requirements
Module: matrix_unary_unit

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, signed element width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 5, largest square dimension supported (2..8).
REQ-003 SHALL have parameter LANES, default 5, elements processed per RUN cycle (1..MAX_DIM*MAX_DIM).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have start  in  1  request, sampled only in IDLE or DONE.
REQ-006 SHALL have op  in  2  operation: 00 negate, 01 scalar multiply, 10 absolute value, 11 pass-through.
REQ-007 SHALL have matrix_size  in  3  size code c, dimension N=c+2; codes giving N>MAX_DIM clamp to MAX_DIM.
REQ-008 SHALL have scalar  in  ELEM_W  signed multiplier for op 01.
REQ-009 SHALL have matrix_a  in  ELEM_W*MAX_DIM*MAX_DIM  row-major operand, element i at bits [i*ELEM_W +: ELEM_W].
REQ-010 SHALL have result  out  ELEM_W*MAX_DIM*MAX_DIM  row-major result, same packing.
REQ-011 SHALL have busy  out  1, done  out  1, result_valid  out  1, overflow  out  1.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE; DONE -> RUN on start, else hold DONE.
REQ-013 SHALL, on start in IDLE/DONE, register matrix_a, op, scalar, clamped N; clear result, overflow, result_valid; enter RUN next cycle.
REQ-014 SHALL in each RUN cycle write elements idx..idx+LANES-1 (only those < N*N), idx starting at 0, advancing by LANES.
REQ-015 SHALL spend exactly ceil(N*N/LANES) cycles in RUN, then enter DONE.
REQ-016 SHALL assert busy exactly while in RUN.
REQ-017 SHALL pulse done for exactly one cycle, the first DONE cycle; result_valid rises with it and holds until next accepted start.
REQ-018 SHALL hold every element index >= N*N at zero.
REQ-019 SHALL compute all ops at full precision then saturate to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
REQ-020 SHALL set overflow (sticky until next start) if any element saturated; e.g. negate/abs of -128 -> 127.
REQ-021 SHALL ignore start while in RUN; captured operands stay stable.
REQ-022 SHALL keep result unchanged in DONE regardless of input changes.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, enter IDLE and drive result=0, busy=0, done=0, result_valid=0, overflow=0, index=0.
REQ-024 SHALL abort a RUN in progress on reset with no done pulse; start sampled in the same cycle as reset is ignored.

Structure
REQ-025 SHALL place op-code constants, size-code-to-dimension function and default ELEM_W/MAX_DIM in shared package matrix_pkg.
REQ-026 SHALL instantiate LANES copies of one combinational sub-module matrix_elem_alu (element, op, scalar -> saturated result, sat flag).

Verification
REQ-027 SHALL cover: N=2 negate, a={5,-3,0,127}, LANES=5 -> 1 RUN cycle, result {-5,3,0,-127}, rest 0, overflow=0.
REQ-028 SHALL cover: N=5 negate, element 7=-128 -> 5 RUN cycles, done on cycle 6 after start, element 7=127, overflow=1.
REQ-029 SHALL cover: N=3 scalar=4, a=all 40 -> all nine =127, overflow=1; scalar=-2, a=all 10 -> all -20, overflow=0.
REQ-030 SHALL cover: N=4 abs, LANES=3 -> 6 RUN cycles; start pulsed mid-RUN ignored, busy stays high.
REQ-031 SHALL cover: rst_n=0 on RUN cycle 2 -> IDLE next cycle, all outputs 0, no done pulse.
REQ-032 SHALL cover: back-to-back start in DONE cycle -> result_valid drops, new RUN begins next cycle.
